// File: rtl/ifft_8_stream.sv
// Streaming 8-point inverse DFT: collects X[0..7], runs three radix-2 DIT stages
// (one per cycle) and emits x[0..7] with a valid/ready handshake.
module ifft_8_stream #(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [(2**N)-1:0]   in_r,
   input  logic [(2**N)-1:0]   in_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [(2**N)-1:0]   out_r,
   output logic [(2**N)-1:0]   out_i,
   output logic [2:0]          out_idx
);

   localparam int W  = 2**N;
   localparam int DW = W + 3;
   localparam logic [2:0] BR [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

   typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

   state_t                state_reg, state_next;
   logic [2:0]            in_cnt_reg;
   logic [1:0]            stage_cnt_reg;
   logic                  out_valid_reg;
   logic [2:0]            out_idx_reg;
   logic signed [W-1:0]   sample_r_reg [8];
   logic signed [W-1:0]   sample_i_reg [8];
   logic signed [DW-1:0]  st_r_reg [8];
   logic signed [DW-1:0]  st_i_reg [8];
   logic signed [DW-1:0]  st_r_next [8];
   logic signed [DW-1:0]  st_i_next [8];
   logic signed [DW-1:0]  tw_r [4];
   logic signed [DW-1:0]  tw_i [4];
   logic signed [DW-1:0]  sel_r, sel_i;
   logic                  in_fire, out_fire;

   function automatic logic signed [DW-1:0] sx(input logic signed [W-1:0] v);
      return {{3{v[W-1]}}, v};
   endfunction

   function automatic logic signed [DW:0] ext1(input logic signed [DW-1:0] v);
      return {v[DW-1], v};
   endfunction

   // sqrt(2)/2 approximated as 181/256, floor rounding
   function automatic logic signed [DW-1:0] mul181(input logic signed [DW:0] v);
      logic signed [DW+10:0] p;
      p = v * 11'sd181;
      return p[DW+7:8];
   endfunction

   assign in_ready = (state_reg == COLLECT);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid_reg & out_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COLLECT: if (in_fire && in_cnt_reg == 3'd7) state_next = COMPUTE;
         COMPUTE: if (stage_cnt_reg == 2'd2) state_next = EMIT;
         EMIT:    if (out_fire && out_idx_reg == 3'd7) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= COLLECT;
      else     state_reg <= state_next;
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_sample
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sample_r_reg[gi] <= '0;
               sample_i_reg[gi] <= '0;
            end else if (in_fire && in_cnt_reg == 3'(gi)) begin
               sample_r_reg[gi] <= in_r;
               sample_i_reg[gi] <= in_i;
            end
         end
      end
   endgenerate

   // Conjugate (inverse) twiddles applied to the upper half in the last stage
   always_comb begin
      tw_r[0] = st_r_reg[4];
      tw_i[0] = st_i_reg[4];
      tw_r[1] = mul181(ext1(st_r_reg[5]) - ext1(st_i_reg[5]));
      tw_i[1] = mul181(ext1(st_r_reg[5]) + ext1(st_i_reg[5]));
      tw_r[2] = -st_i_reg[6];
      tw_i[2] = st_r_reg[6];
      tw_r[3] = mul181(-(ext1(st_r_reg[7]) + ext1(st_i_reg[7])));
      tw_i[3] = mul181(ext1(st_r_reg[7]) - ext1(st_i_reg[7]));
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         st_r_next[i] = st_r_reg[i];
         st_i_next[i] = st_i_reg[i];
      end
      case (stage_cnt_reg)
         2'd0: begin
            // bit-reversed fetch lets the final stage land in natural order
            for (int m = 0; m < 4; m++) begin
               st_r_next[2*m]   = sx(sample_r_reg[BR[2*m]]) + sx(sample_r_reg[BR[2*m+1]]);
               st_i_next[2*m]   = sx(sample_i_reg[BR[2*m]]) + sx(sample_i_reg[BR[2*m+1]]);
               st_r_next[2*m+1] = sx(sample_r_reg[BR[2*m]]) - sx(sample_r_reg[BR[2*m+1]]);
               st_i_next[2*m+1] = sx(sample_i_reg[BR[2*m]]) - sx(sample_i_reg[BR[2*m+1]]);
            end
         end
         2'd1: begin
            for (int q = 0; q < 2; q++) begin
               st_r_next[4*q]   = st_r_reg[4*q] + st_r_reg[4*q+2];
               st_i_next[4*q]   = st_i_reg[4*q] + st_i_reg[4*q+2];
               st_r_next[4*q+2] = st_r_reg[4*q] - st_r_reg[4*q+2];
               st_i_next[4*q+2] = st_i_reg[4*q] - st_i_reg[4*q+2];
               st_r_next[4*q+1] = st_r_reg[4*q+1] - st_i_reg[4*q+3];
               st_i_next[4*q+1] = st_i_reg[4*q+1] + st_r_reg[4*q+3];
               st_r_next[4*q+3] = st_r_reg[4*q+1] + st_i_reg[4*q+3];
               st_i_next[4*q+3] = st_i_reg[4*q+1] - st_r_reg[4*q+3];
            end
         end
         2'd2: begin
            for (int j = 0; j < 4; j++) begin
               st_r_next[j]   = st_r_reg[j] + tw_r[j];
               st_i_next[j]   = st_i_reg[j] + tw_i[j];
               st_r_next[j+4] = st_r_reg[j] - tw_r[j];
               st_i_next[j+4] = st_i_reg[j] - tw_i[j];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt_reg    <= '0;
         stage_cnt_reg <= '0;
         out_valid_reg <= 1'b0;
         out_idx_reg   <= '0;
         for (int i = 0; i < 8; i++) begin
            st_r_reg[i] <= '0;
            st_i_reg[i] <= '0;
         end
      end else begin
         if (in_fire) in_cnt_reg <= in_cnt_reg + 3'd1;
         if (state_reg == COMPUTE) begin
            stage_cnt_reg <= (stage_cnt_reg == 2'd2) ? 2'd0 : stage_cnt_reg + 2'd1;
            for (int i = 0; i < 8; i++) begin
               st_r_reg[i] <= st_r_next[i];
               st_i_reg[i] <= st_i_next[i];
            end
         end
         // first EMIT cycle only raises valid, giving the extra output register stage
         if (state_reg == EMIT) begin
            if (!out_valid_reg) begin
               out_valid_reg <= 1'b1;
            end else if (out_ready) begin
               if (out_idx_reg == 3'd7) begin
                  out_valid_reg <= 1'b0;
                  out_idx_reg   <= '0;
               end else begin
                  out_idx_reg <= out_idx_reg + 3'd1;
               end
            end
         end
      end
   end

   assign sel_r     = st_r_reg[out_idx_reg];
   assign sel_i     = st_i_reg[out_idx_reg];
   assign out_valid = out_valid_reg;
   assign out_idx   = out_idx_reg;
   assign out_r     = out_valid_reg ? sel_r[DW-1:3] : '0;
   assign out_i     = out_valid_reg ? sel_i[DW-1:3] : '0;

endmodule

// File: tb/tb_ifft_8_stream.sv
// Directed bench for ifft_8_stream: impulse, DC, tone, backpressure, gaps, mid-frame reset.
module tb_ifft_8_stream;

   localparam int N = 4;
   localparam int W = 2**N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_r = '0;
   logic [W-1:0]  in_i = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_r;
   logic [W-1:0]  out_i;
   logic [2:0]    out_idx;

   int total  = 0;
   int passed = 0;

   ifft_8_stream #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_i(out_i), .out_idx(out_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic send_frame(input string name, input int xr[8], input int xi[8], input bit gaps);
      for (int k = 0; k < 8; k++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 2));
            repeat (g) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_r = W'($urandom);
               in_i = W'($urandom);
            end
         end
         @(negedge clk);
         check($sformatf("%s in_ready k%0d", name, k), int'(in_ready), 1);
         in_valid = 1'b1;
         in_r = xr[k][W-1:0];
         in_i = xi[k][W-1:0];
         @(posedge clk);
      end
   endtask

   task automatic recv_frame(input string name, input int er[8], input int ei[8],
                             input bit [3:0] rdy_pat, input bit junk, input int max_beats);
      int n = 0, edges = 0, cyc = 0;
      bit seen = 0, fire;
      while (n < max_beats && edges < 60) begin
         @(negedge clk);
         in_valid = junk && ($urandom_range(0, 1) == 1) && !(out_valid && n == 7);
         in_r = W'($urandom);
         in_i = W'($urandom);
         out_ready = rdy_pat[3 - (cyc % 4)];
         fire = 1'b0;
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               check($sformatf("%s latency", name), edges, 4);
            end
            check($sformatf("%s idx n%0d", name, n), int'(out_idx), n);
            check($sformatf("%s re n%0d", name, n), int'($signed(out_r)), er[n]);
            check($sformatf("%s im n%0d", name, n), int'($signed(out_i)), ei[n]);
            check($sformatf("%s in_ready busy n%0d", name, n), int'(in_ready), 0);
            fire = out_ready;
            cyc++;
         end
         @(posedge clk);
         edges++;
         if (fire) n++;
      end
      if (n < max_beats) check($sformatf("%s beat timeout", name), n, max_beats);
      if (max_beats == 8) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b0;
         check($sformatf("%s out_valid after", name), int'(out_valid), 0);
         check($sformatf("%s in_ready after", name), int'(in_ready), 1);
         check($sformatf("%s out_idx after", name), int'(out_idx), 0);
      end
   endtask

   int zero[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
   int imp[8]    = '{8, 0, 0, 0, 0, 0, 0, 0};
   int ones[8]   = '{1, 1, 1, 1, 1, 1, 1, 1};
   int dc[8]     = '{8, 8, 8, 8, 8, 8, 8, 8};
   int tone[8]   = '{0, 2048, 0, 0, 0, 0, 0, 0};
   int tone_r[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
   int tone_i[8] = '{0, 181, 256, 181, 0, -181, -256, -181};

   initial begin
      repeat (2) @(negedge clk);
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_r", int'(out_r), 0);
      check("reset out_i", int'(out_i), 0);
      check("reset out_idx", int'(out_idx), 0);
      rst = 1'b0;

      send_frame("impulse", imp, zero, 1'b0);
      recv_frame("impulse", ones, zero, 4'b1111, 1'b0, 8);

      send_frame("dc", dc, zero, 1'b0);
      recv_frame("dc", imp, zero, 4'b1111, 1'b0, 8);

      send_frame("tone", tone, zero, 1'b0);
      recv_frame("tone", tone_r, tone_i, 4'b1111, 1'b0, 8);

      send_frame("bp", dc, zero, 1'b0);
      recv_frame("bp", imp, zero, 4'b1001, 1'b0, 8);

      send_frame("gaps", imp, zero, 1'b1);
      recv_frame("gaps", ones, zero, 4'b1111, 1'b1, 8);

      send_frame("pre_rst", imp, zero, 1'b0);
      recv_frame("pre_rst", ones, zero, 4'b1111, 1'b0, 4);
      @(negedge clk);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst out_valid", int'(out_valid), 0);
      check("midrst in_ready", int'(in_ready), 1);
      check("midrst out_idx", int'(out_idx), 0);
      @(negedge clk);
      check("midrst held out_valid", int'(out_valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("postrst out_valid", int'(out_valid), 0);

      send_frame("post_rst", imp, zero, 1'b0);
      recv_frame("post_rst", ones, zero, 4'b1111, 1'b0, 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
